// File: rtl/button_pkg.sv
// Shared types and helpers for the push-button debounce/edge/repeat block.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CHK,
    PRESSED,
    REL_CHK
  } btn_state_t;

  typedef enum logic {
    DELAY,
    PERIOD
  } rep_phase_t;

  // Counter width for a terminal count of x: $clog2(x), never less than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned x);
    int unsigned w;
    w = $clog2(x);
    return (w > 1) ? w : 1;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button: 2-flop synchronizer, debounce FSM, edge strobes and auto-repeat.
module button_channel
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_DELAY    = 2500000,
  parameter int unsigned REPEAT_PERIOD   = 500000
) (
  input  logic clk_in,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_repeat
);

  localparam int unsigned DB_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned REP_W   = cnt_width(REP_MAX);
  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);
  localparam logic             REP_EN      = (REPEAT_DELAY > 0);

  logic             sync1_q, sync_q;
  btn_state_t       state_q, state_d;
  rep_phase_t       phase_q, phase_d;
  logic [DB_W-1:0]  db_q, db_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [REP_W-1:0] rep_last;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             repeat_q, repeat_d;

  assign rep_last = (phase_q == DELAY) ? DELAY_LAST : PERIOD_LAST;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    db_d      = db_q;
    rep_d     = rep_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync_q) begin
          state_d = PRESS_CHK;
          db_d    = '0;
        end
      end
      PRESS_CHK: begin
        if (!sync_q) begin
          state_d = IDLE;
        end else if (db_q == DB_LAST) begin
          state_d = PRESSED;
          press_d = 1'b1;
          rep_d   = '0;
          phase_d = DELAY;
        end else begin
          db_d = db_q + DB_W'(1);
        end
      end
      PRESSED: begin
        if (!sync_q) begin
          state_d = REL_CHK;
          db_d    = '0;
        end else if (REP_EN) begin
          if (rep_q == rep_last) begin
            repeat_d = 1'b1;
            rep_d    = '0;
            phase_d  = PERIOD;
          end else begin
            rep_d = rep_q + REP_W'(1);
          end
        end
      end
      REL_CHK: begin
        // Bouncing back to PRESSED keeps the repeat schedule where it was.
        if (sync_q) begin
          state_d = PRESSED;
        end else if (db_q == DB_LAST) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end else begin
          db_d = db_q + DB_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    level_d = (state_d == PRESSED) || (state_d == REL_CHK);
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync_q    <= 1'b0;
      state_q   <= IDLE;
      phase_q   <= DELAY;
      db_q      <= '0;
      rep_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      sync1_q   <= btn_raw;
      sync_q    <= sync1_q;
      state_q   <= state_d;
      phase_q   <= phase_d;
      db_q      <= db_d;
      rep_q     <= rep_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_repeat  = repeat_q;

endmodule

// File: rtl/button_debouncer.sv
// Calculator push-button front end: NUM_BTNS independent debounce/repeat channels.
module button_debouncer #(
  parameter int unsigned NUM_BTNS        = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_DELAY    = 2500000,
  parameter int unsigned REPEAT_PERIOD   = 500000
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic [NUM_BTNS-1:0] btn_raw,
  output logic [NUM_BTNS-1:0] btn_level,
  output logic [NUM_BTNS-1:0] btn_press,
  output logic [NUM_BTNS-1:0] btn_release,
  output logic [NUM_BTNS-1:0] btn_repeat
);

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk_in     (clk_in),
      .rst        (rst),
      .btn_raw    (btn_raw[i]),
      .btn_level  (btn_level[i]),
      .btn_press  (btn_press[i]),
      .btn_release(btn_release[i]),
      .btn_repeat (btn_repeat[i])
    );
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed plus randomized bench for button_debouncer against a run-length reference model.
module tb_button_debouncer;

  localparam int N  = 2;
  localparam int D  = 4;
  localparam int RD = 8;
  localparam int RP = 4;

  logic         clk_in = 1'b0;
  logic         rst;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_repeat;

  always #5 clk_in = ~clk_in;

  button_debouncer #(
    .NUM_BTNS       (N),
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_repeat (btn_repeat)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: accepted level, length of the current run of samples
  // disagreeing with it, and count of held ticks since the press.
  bit           acc [N];
  int           run [N];
  int           held[N];
  bit           dly [N][2];
  logic [N-1:0] e_level, e_press, e_rel, e_rep;

  int last_press[N], last_rel[N], n_press[N], n_rel[N];
  int rep_edges[$];

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge(input logic [N-1:0] raw, input logic r);
    bit x;
    e_press = '0;
    e_rel   = '0;
    e_rep   = '0;
    for (int c = 0; c < N; c++) begin
      if (r) begin
        acc[c] = 0; run[c] = 0; held[c] = 0; dly[c][0] = 0; dly[c][1] = 0;
      end else begin
        x         = dly[c][1];
        dly[c][1] = dly[c][0];
        dly[c][0] = raw[c];
        if (x != acc[c]) begin
          run[c]++;
          if (run[c] == D + 1) begin
            acc[c] = ~acc[c];
            run[c] = 0;
            if (acc[c]) begin
              e_press[c] = 1'b1;
              held[c]    = 0;
            end else begin
              e_rel[c] = 1'b1;
            end
          end
        end else begin
          if (acc[c] && run[c] == 0 && RD > 0) begin
            held[c]++;
            if (held[c] >= RD && ((held[c] - RD) % RP) == 0) e_rep[c] = 1'b1;
          end
          run[c] = 0;
        end
      end
      e_level[c] = acc[c];
    end
  endtask

  task automatic step(input logic [N-1:0] raw, input logic r);
    btn_raw = raw;
    rst     = r;
    @(posedge clk_in);
    cyc++;
    model_edge(raw, r);
    #1;
    chk("level",   btn_level,   e_level);
    chk("press",   btn_press,   e_press);
    chk("release", btn_release, e_rel);
    chk("repeat",  btn_repeat,  e_rep);
    for (int c = 0; c < N; c++) begin
      if (btn_press[c] === 1'b1)   begin last_press[c] = cyc; n_press[c]++; end
      if (btn_release[c] === 1'b1) begin last_rel[c] = cyc;   n_rel[c]++;   end
    end
    if (btn_repeat[0] === 1'b1) rep_edges.push_back(cyc);
  endtask

  initial begin
    int base, p0, r0, hold[N];
    logic [N-1:0] rv;
    logic         rr;

    for (int c = 0; c < N; c++) begin
      last_press[c] = -1; last_rel[c] = -1; n_press[c] = 0; n_rel[c] = 0; hold[c] = 0;
    end
    btn_raw = '0;
    rst     = 1'b1;

    // Reset, then clean press sampled at edge 10 and held for auto-repeat.
    step(2'b00, 1'b1);
    step(2'b00, 1'b1);
    chk("reset_outs", btn_level | btn_press | btn_release | btn_repeat, 2'b00);
    repeat (7) step(2'b00, 1'b0);
    repeat (24) step(2'b01, 1'b0);
    chk_int("clean_press_edge", last_press[0], 16);
    chk_int("repeat_count", rep_edges.size(), 3);
    if (rep_edges.size() == 3) begin
      chk_int("repeat_edge0", rep_edges[0], 24);
      chk_int("repeat_edge1", rep_edges[1], 28);
      chk_int("repeat_edge2", rep_edges[2], 32);
    end

    // Two-cycle glitch while held.
    base = n_rel[0];
    p0   = n_press[0];
    repeat (2) step(2'b00, 1'b0);
    repeat (6) step(2'b01, 1'b0);
    chk_int("glitch_no_release", n_rel[0], base);
    chk_int("glitch_no_press", n_press[0], p0);
    chk("glitch_level", btn_level, 2'b01);

    // Release.
    r0 = cyc + 1;
    repeat (10) step(2'b00, 1'b0);
    chk_int("release_edge", last_rel[0], r0 + 6);

    // Bounce then settle high.
    p0 = n_press[0];
    step(2'b01, 1'b0); step(2'b00, 1'b0); step(2'b01, 1'b0); step(2'b00, 1'b0);
    base = cyc + 1;
    repeat (10) step(2'b01, 1'b0);
    chk_int("bounce_press_edge", last_press[0], base + 6);
    chk_int("bounce_single_press", n_press[0], p0 + 1);
    repeat (8) step(2'b00, 1'b0);

    // Reset while PRESS_CHK has counted to 2.
    p0 = n_press[0];
    repeat (5) step(2'b01, 1'b0);
    base = cyc + 1;
    step(2'b01, 1'b1);
    chk("midreset_outs", btn_level | btn_press | btn_release | btn_repeat, 2'b00);
    repeat (10) step(2'b01, 1'b0);
    chk_int("midreset_press_edge", last_press[0], base + 7);
    chk_int("midreset_one_press", n_press[0], p0 + 1);
    repeat (8) step(2'b00, 1'b0);

    // Simultaneous channels, then release only channel 1.
    base = cyc + 1;
    repeat (8) step(2'b11, 1'b0);
    chk_int("simul_press0", last_press[0], base + 6);
    chk_int("simul_press1", last_press[1], base + 6);
    r0   = last_rel[0];
    base = cyc + 1;
    repeat (8) step(2'b01, 1'b0);
    chk_int("simul_release1", last_rel[1], base + 6);
    chk_int("simul_no_release0", last_rel[0], r0);
    repeat (8) step(2'b00, 1'b0);

    // Randomized holds and bounces with occasional reset.
    for (int k = 0; k < 800; k++) begin
      for (int c = 0; c < N; c++) begin
        if (hold[c] == 0) begin
          rv[c]   = 1'($urandom_range(0, 1));
          hold[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 40)) : int'($urandom_range(1, 6));
        end
        hold[c]--;
      end
      rr = ($urandom_range(0, 299) == 0);
      step(rv, rr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
